// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the control pipeline: the packed control bundle,
// its bit positions, the bubble value and the WBSrc / ExOp encodings.
// Configuration: CTRL_PIPE_FP_EN (see ctrl_pipe) changes how the Float and DW
// bits are treated; the definitions here are the same in both builds.
package ctrl_pkg;

    // Bit positions inside the 16-bit control bundle
    localparam int JR_BIT       = 15;
    localparam int BYTE_BIT     = 14;
    localparam int JUMP_BIT     = 13;
    localparam int MEMWRITE_BIT = 12;
    localparam int REGWRITE_BIT = 11;
    localparam int FLOAT_BIT    = 10;
    localparam int SHIFT_BIT    = 9;
    localparam int DW_BIT       = 8;

    typedef struct packed {
        logic       jr;
        logic       byteOp;
        logic       jump;
        logic       memWrite;
        logic       regWrite;
        logic       isFloat;
        logic       shift;
        logic       dw;
        logic [1:0] regDst;
        logic [2:0] wbSrc;
        logic [2:0] exOp;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Float and DW bits; stripped from every stage when FP support is off
    localparam logic [15:0] CTRL_FP_MASK = (16'h1 << FLOAT_BIT) | (16'h1 << DW_BIT);

    typedef enum logic [2:0] {
        WBSRC_ALU = 3'd0,
        WBSRC_MEM = 3'd1,
        WBSRC_LUI = 3'd2,
        WBSRC_PC4 = 3'd3
    } wbSrc_e;

    typedef enum logic [2:0] {
        EXOP_ADD    = 3'b000,
        EXOP_SUB    = 3'b001,
        EXOP_MULDIV = 3'b010,
        EXOP_AND    = 3'b011,
        EXOP_OR     = 3'b100,
        EXOP_SLT    = 3'b101,
        EXOP_SHIFT  = 3'b111
    } exOp_e;

endpackage

// File: rtl/ctrl_pipe_hazard_detect.sv
// hazard_detect
// Combinational load-use detection between the instruction in EX and the
// instruction waiting in ID.
// Ports:
//   idValid            ID holds a real instruction
//   idRs, idRt         ID source register indices
//   exRegWrite/exWbSrc EX instruction writes a register from memory (a load)
//   exDest             EX destination index
//   exFloat, exDw      (CTRL_PIPE_FP_EN only) EX register domain / double word
//   idFloat            (CTRL_PIPE_FP_EN only) ID consumer register domain
//   lu                 load-use hazard
// Configuration: CTRL_PIPE_FP_EN adds FP-domain and double-word matching.
module hazard_detect
    import ctrl_pkg::*;
(
    input  logic       idValid,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic       exRegWrite,
    input  logic [2:0] exWbSrc,
    input  logic [4:0] exDest,
`ifdef CTRL_PIPE_FP_EN
    input  logic       exFloat,
    input  logic       exDw,
    input  logic       idFloat,
`endif
    output logic       lu
);

    logic exIsLoad;
    logic destMatch;
    logic destLive;

    assign exIsLoad = exRegWrite && (exWbSrc == WBSRC_MEM);

`ifdef CTRL_PIPE_FP_EN
    // A double-word load writes an even/odd register pair, so the low index
    // bit is ignored. Register 0 is only hardwired in the integer file, and
    // a load in the other register domain never conflicts.
    always_comb begin
        destMatch = 1'b0;
        if (exDw) begin
            destMatch = (exDest[4:1] == idRs[4:1]) || (exDest[4:1] == idRt[4:1]);
        end else begin
            destMatch = (exDest == idRs) || (exDest == idRt);
        end
    end

    assign destLive = (exFloat == idFloat) && (exFloat || (exDest != 5'd0));
`else
    assign destMatch = (exDest == idRs) || (exDest == idRt);
    assign destLive  = (exDest != 5'd0);
`endif

    assign lu = idValid && exIsLoad && destLive && destMatch;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe
// Carries the decoded control bundle through the ID/EX, EX/MEM and MEM/WB
// registers, inserts load-use bubbles, holds EX for multi-cycle mult/div and
// squashes wrong-path instructions on jumps and taken branches.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_valid, id_ctrl            ID instruction valid flag and control bundle
//   id_muldiv                    ID instruction is a mult/div
//   id_rs, id_rt, id_dest        ID source and destination indices
//   id_float                     (CTRL_PIPE_FP_EN only) ID consumer domain
//   ex_branch_taken              branch in EX resolved taken
//   ex/mem/wb_ctrl, *_dest       per-stage control bundle and destination
//   stall                        hold PC and IF/ID
//   flush_if                     turn IF/ID into a bubble
// Configuration: define CTRL_PIPE_FP_EN to keep the Float/DW bits and enable
// FP-aware load-use matching; otherwise those bits are cleared at entry.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [15:0] id_ctrl,
    input  logic        id_muldiv,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dest,
`ifdef CTRL_PIPE_FP_EN
    input  logic        id_float,
`endif
    input  logic        ex_branch_taken,
    output logic [15:0] ex_ctrl,
    output logic [15:0] mem_ctrl,
    output logic [15:0] wb_ctrl,
    output logic [4:0]  ex_dest,
    output logic [4:0]  mem_dest,
    output logic [4:0]  wb_dest,
    output logic        stall,
    output logic        flush_if
);

    // Count loaded when a mult/div enters EX; it occupies EX for the load
    // cycle plus MULDIV_LAT-1 held cycles.
    localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 1);

    ctrl_t      exBundle;
    ctrl_t      idBundle;
    logic [15:0] idCtrlClean;
    logic       exMuldiv;
    logic [3:0] mdCnt;
    logic       mdBusy;
    logic       lu;

    assign exBundle = ctrl_t'(ex_ctrl);
    assign idBundle = ctrl_t'(id_ctrl);

`ifdef CTRL_PIPE_FP_EN
    assign idCtrlClean = id_ctrl;
`else
    assign idCtrlClean = id_ctrl & ~CTRL_FP_MASK;
`endif

    // The counter is only nonzero while the mult/div sits in EX; the
    // exMuldiv term keeps the two views tied together.
    assign mdBusy = exMuldiv && (mdCnt != 4'd0);

    hazard_detect uHazard (
        .idValid    (id_valid),
        .idRs       (id_rs),
        .idRt       (id_rt),
        .exRegWrite (exBundle.regWrite),
        .exWbSrc    (exBundle.wbSrc),
        .exDest     (ex_dest),
`ifdef CTRL_PIPE_FP_EN
        .exFloat    (exBundle.isFloat),
        .exDw       (exBundle.dw),
        .idFloat    (id_float),
`endif
        .lu         (lu)
    );

    // A taken branch wins over both stall sources; a jump in ID only flushes
    // the fetch slot when it is actually allowed to advance.
    always_comb begin
        stall    = 1'b0;
        flush_if = 1'b0;
        if (ex_branch_taken) begin
            flush_if = 1'b1;
        end else begin
            stall    = mdBusy || lu;
            flush_if = id_valid && idBundle.jump && !(mdBusy || lu);
        end
    end

    // Stage registers and mult/div counter, in priority order:
    // reset, taken branch, mult/div hold, load-use bubble, normal advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl  <= CTRL_BUBBLE;
            mem_ctrl <= CTRL_BUBBLE;
            wb_ctrl  <= CTRL_BUBBLE;
            ex_dest  <= 5'd0;
            mem_dest <= 5'd0;
            wb_dest  <= 5'd0;
            exMuldiv <= 1'b0;
            mdCnt    <= 4'd0;
        end else if (ex_branch_taken) begin
            ex_ctrl  <= CTRL_BUBBLE;
            ex_dest  <= 5'd0;
            exMuldiv <= 1'b0;
            mdCnt    <= 4'd0;
            mem_ctrl <= ex_ctrl;
            mem_dest <= ex_dest;
            wb_ctrl  <= mem_ctrl;
            wb_dest  <= mem_dest;
        end else if (mdBusy) begin
            mdCnt    <= mdCnt - 4'd1;
            mem_ctrl <= CTRL_BUBBLE;
            mem_dest <= 5'd0;
            wb_ctrl  <= mem_ctrl;
            wb_dest  <= mem_dest;
        end else if (lu) begin
            ex_ctrl  <= CTRL_BUBBLE;
            ex_dest  <= 5'd0;
            exMuldiv <= 1'b0;
            mem_ctrl <= ex_ctrl;
            mem_dest <= ex_dest;
            wb_ctrl  <= mem_ctrl;
            wb_dest  <= mem_dest;
        end else begin
            if (id_valid) begin
                ex_ctrl  <= idCtrlClean;
                ex_dest  <= id_dest;
                exMuldiv <= id_muldiv;
                mdCnt    <= id_muldiv ? MD_LOAD : 4'd0;
            end else begin
                ex_ctrl  <= CTRL_BUBBLE;
                ex_dest  <= 5'd0;
                exMuldiv <= 1'b0;
                mdCnt    <= 4'd0;
            end
            mem_ctrl <= ex_ctrl;
            mem_dest <= ex_dest;
            wb_ctrl  <= mem_ctrl;
            wb_dest  <= mem_dest;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe
// Directed testbench for ctrl_pipe with hand-computed expected values:
// latency, load-use bubble, r0 exclusion, mult/div hold, branch override,
// jump flush, reset abort and Float/DW handling (CTRL_PIPE_FP_EN aware).
module tb_ctrl_pipe;

    localparam logic [15:0] ADD   = 16'h0800;
    localparam logic [15:0] LW    = 16'h0808;
    localparam logic [15:0] MUL   = 16'h0002;
    localparam logic [15:0] JUMP  = 16'h2000;
    localparam logic [15:0] FPADD = 16'h0D00;
    localparam logic [15:0] LDC1  = 16'h0D08;

    logic        clk = 1'b0;
    logic        rst;
    logic        idValid;
    logic [15:0] idCtrl;
    logic        idMuldiv;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic [4:0]  idDest;
    logic        idFloat;
    logic        branchTaken;
    logic [15:0] exCtrl;
    logic [15:0] memCtrl;
    logic [15:0] wbCtrl;
    logic [4:0]  exDest;
    logic [4:0]  memDest;
    logic [4:0]  wbDest;
    logic        stall;
    logic        flushIf;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.MULDIV_LAT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (idValid),
        .id_ctrl         (idCtrl),
        .id_muldiv       (idMuldiv),
        .id_rs           (idRs),
        .id_rt           (idRt),
        .id_dest         (idDest),
`ifdef CTRL_PIPE_FP_EN
        .id_float        (idFloat),
`endif
        .ex_branch_taken (branchTaken),
        .ex_ctrl         (exCtrl),
        .mem_ctrl        (memCtrl),
        .wb_ctrl         (wbCtrl),
        .ex_dest         (exDest),
        .mem_dest        (memDest),
        .wb_dest         (wbDest),
        .stall           (stall),
        .flush_if        (flushIf)
    );

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the ID-side inputs, then let the combinational outputs settle
    task automatic applyStimulus(input logic valid, input logic [15:0] ctrl,
                                 input logic muldiv, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] dest,
                                 input logic br);
        idValid     = valid;
        idCtrl      = ctrl;
        idMuldiv    = muldiv;
        idRs        = rs;
        idRt        = rt;
        idDest      = dest;
        branchTaken = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ex_ctrl"},  {16'h0, exCtrl},  32'h0);
        checkOutput({tag, " mem_ctrl"}, {16'h0, memCtrl}, 32'h0);
        checkOutput({tag, " wb_ctrl"},  {16'h0, wbCtrl},  32'h0);
        checkOutput({tag, " dests"},    {17'h0, exDest, memDest, wbDest}, 32'h0);
        checkOutput({tag, " stall"},    {31'h0, stall},   32'h0);
    endtask

    initial begin
        rst     = 1'b1;
        idFloat = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkAllZero("reset");
        checkOutput("reset flush_if", {31'h0, flushIf}, 32'h0);

        // Plain add: 1/2/3 cycle latency through EX/MEM/WB
        applyStimulus(1'b1, ADD, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
        checkOutput("add stall", {31'h0, stall}, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("lat ex_ctrl", {16'h0, exCtrl}, {16'h0, ADD});
        checkOutput("lat ex_dest", {27'h0, exDest}, 32'd3);
        tick();
        checkOutput("lat mem_ctrl", {16'h0, memCtrl}, {16'h0, ADD});
        tick();
        checkOutput("lat wb_ctrl", {16'h0, wbCtrl}, {16'h0, ADD});
        checkOutput("lat wb_dest", {27'h0, wbDest}, 32'd3);

        // Load-use: lw r8 then add using r8 -> exactly one bubble
        applyStimulus(1'b1, LW, 1'b0, 5'd0, 5'd0, 5'd8, 1'b0);
        tick();
        applyStimulus(1'b1, ADD, 1'b0, 5'd8, 5'd9, 5'd10, 1'b0);
        checkOutput("lu stall", {31'h0, stall}, 32'h1);
        tick();
        checkOutput("lu bubble ex_ctrl", {16'h0, exCtrl}, 32'h0);
        checkOutput("lu mem_ctrl", {16'h0, memCtrl}, {16'h0, LW});
        checkOutput("lu stall released", {31'h0, stall}, 32'h0);
        tick();
        checkOutput("lu consumer ex_ctrl", {16'h0, exCtrl}, {16'h0, ADD});
        checkOutput("lu consumer ex_dest", {27'h0, exDest}, 32'd10);

        // Load to r0 never causes a hazard
        applyStimulus(1'b1, LW, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, ADD, 1'b0, 5'd0, 5'd0, 5'd11, 1'b0);
        checkOutput("r0 stall", {31'h0, stall}, 32'h0);
        tick();
        checkOutput("r0 ex_ctrl", {16'h0, exCtrl}, {16'h0, ADD});

        // Mult with latency 4: three stall cycles, MEM gets bubbles
        applyStimulus(1'b1, MUL, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, ADD, 1'b0, 5'd1, 5'd2, 5'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("md stall %0d", i), {31'h0, stall}, 32'h1);
            tick();
            checkOutput($sformatf("md mem bubble %0d", i), {16'h0, memCtrl}, 32'h0);
            checkOutput($sformatf("md ex hold %0d", i), {16'h0, exCtrl}, {16'h0, MUL});
        end
        checkOutput("md stall done", {31'h0, stall}, 32'h0);
        tick();
        checkOutput("md next ex_ctrl", {16'h0, exCtrl}, {16'h0, ADD});
        checkOutput("md mem_ctrl", {16'h0, memCtrl}, {16'h0, MUL});

        // Taken branch overrides a load-use hazard
        applyStimulus(1'b1, LW, 1'b0, 5'd0, 5'd0, 5'd8, 1'b0);
        tick();
        applyStimulus(1'b1, ADD, 1'b0, 5'd8, 5'd0, 5'd12, 1'b1);
        checkOutput("br flush_if", {31'h0, flushIf}, 32'h1);
        checkOutput("br stall", {31'h0, stall}, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("br ex_ctrl", {16'h0, exCtrl}, 32'h0);
        checkOutput("br mem_ctrl", {16'h0, memCtrl}, {16'h0, LW});

        // Jump in ID flushes IF but still advances
        applyStimulus(1'b1, JUMP, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("jump flush_if", {31'h0, flushIf}, 32'h1);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("jump ex_ctrl", {16'h0, exCtrl}, {16'h0, JUMP});
        checkOutput("jump flush_if clear", {31'h0, flushIf}, 32'h0);

        // Taken branch kills an in-flight mult/div
        applyStimulus(1'b1, MUL, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        checkOutput("brmd stall", {31'h0, stall}, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("brmd ex_ctrl", {16'h0, exCtrl}, 32'h0);
        checkOutput("brmd stall after", {31'h0, stall}, 32'h0);

        // Reset with two held cycles still to go
        applyStimulus(1'b1, MUL, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        checkOutput("rstmd stall before", {31'h0, stall}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkAllZero("rstmd");
        tick();
        checkOutput("rstmd stall later", {31'h0, stall}, 32'h0);

        // Float/DW bits survive only in the FP build
        applyStimulus(1'b1, FPADD, 1'b0, 5'd1, 5'd2, 5'd6, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`ifdef CTRL_PIPE_FP_EN
        checkOutput("fp bits ex_ctrl", {16'h0, exCtrl}, {16'h0, FPADD});
`else
        checkOutput("fp bits ex_ctrl", {16'h0, exCtrl}, {16'h0, ADD});
`endif
        tick();

`ifdef CTRL_PIPE_FP_EN
        // ldc1 to f4/f5 pair, then an FP reader of f5
        applyStimulus(1'b1, LDC1, 1'b0, 5'd0, 5'd0, 5'd4, 1'b0);
        tick();
        idFloat = 1'b1;
        applyStimulus(1'b1, FPADD, 1'b0, 5'd5, 5'd0, 5'd7, 1'b0);
        checkOutput("ldc1 stall", {31'h0, stall}, 32'h1);
        idFloat = 1'b0;
        #1;
        checkOutput("ldc1 int reader", {31'h0, stall}, 32'h0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control bundle from the ID-stage control unit through the ID/EX, EX/MEM and MEM/WB pipeline registers. Its outputs are the per-stage control signals that the datapath consumes. It also:
- detects load-use hazards and inserts a bubble for each one;
- stalls for multi-cycle multiply/divide;
- squashes wrong-path instructions on jumps and taken branches.

It sits between the control unit and the EX/MEM/WB datapath stages, and drives the IF/ID hold and flush lines.

## Interface
- `MULDIV_LAT`, default 4: cycles a mult/div occupies EX. Legal range is 1..15.
- `clk`  input  1: pipeline clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `id_valid`  input  1: the IF/ID register holds a real instruction.
- `id_ctrl`  input  16: control bundle from decode, packed as `ctrl_t`.
- `id_muldiv`  input  1: the ID instruction is mult/div (R-type fun 24..27).
- `id_rs`, `id_rt`  input  5 each: ID source register indices.
- `id_dest`  input  5: ID destination index, already muxed by RegDst.
- `ex_branch_taken`  input  1: the branch now in EX resolved taken.
- `ex_ctrl`, `mem_ctrl`, `wb_ctrl`  output  16 each: control bundle per stage.
- `ex_dest`, `mem_dest`, `wb_dest`  output  5 each: destination index per stage.
- `stall`  output  1: hold the PC and IF/ID register.
- `flush_if`  output  1: replace the IF/ID contents with a bubble.

## Operation
- `ctrl_t` bit layout:
  - [15] JR, [14] Byte, [13] Jump, [12] MemWrite, [11] RegWrite, [10] Float, [9] Shift, [8] DW
  - [7:6] RegDst, [5:3] WBSrc, [2:0] ExOp
- Bubble encoding: the all-zero bundle with dest 0.
- Each stage register holds a bundle, a dest index, and a muldiv bit (EX only).
- Load-use hazard (`lu`): asserted when all of the following hold:
  - `id_valid`;
  - ex_ctrl.RegWrite = 1 and ex_ctrl.WBSrc = 1;
  - ex_dest ≠ 0;
  - ex_dest equals id_rs or id_rt.
- Mult/div counter `md_cnt` (4 bits):
  - Loads MULDIV_LAT−1 when a muldiv instruction enters EX.
  - Decrements while nonzero.
  - `md_busy` = (md_cnt ≠ 0).
- Priority per cycle, highest first:
  1. `rst`: all stage registers become bubbles and md_cnt = 0.
  2. `ex_branch_taken`: EX←bubble, `flush_if` = 1, `stall` = 0; MEM and WB advance normally. This overrides `lu` and `md_busy`, and clears md_cnt.
  3. `md_busy`: EX holds, MEM←bubble, WB advances, `stall` = 1.
  4. `lu`: EX←bubble, MEM and WB advance, `stall` = 1.
  5. Normal: EX←ID (or a bubble if `id_valid` = 0), MEM←EX, WB←MEM.
- Jump in ID (id_ctrl.Jump, `id_valid`, and no stall): `flush_if` = 1. The jump itself still advances into EX.
- `stall` and `flush_if` are combinational from the current state and inputs.

## Timing
- Reset values: every `*_ctrl` = 16'h0000, every `*_dest` = 0, `stall` = 0, `flush_if` = 0.
- With no hazards, an ID bundle appears on `ex_ctrl` 1 cycle later, on `mem_ctrl` 2 cycles later, and on `wb_ctrl` 3 cycles later.
- Load-use costs exactly one bubble. The consumer enters EX 2 cycles after the load entered EX.
- Mult/div holds EX for MULDIV_LAT cycles total; `stall` is high for MULDIV_LAT−1 cycles. With MULDIV_LAT = 1 there is no stall.
- A reset asserted mid-mult/div aborts it. After that edge `md_cnt` = 0 and `stall` = 0.
- A taken branch during `md_busy` kills the mult/div. Its Hi/Lo side effect belongs to the datapath.

## Configuration
- `CTRL_PIPE_FP_EN` defined:
  - `lu` additionally requires ex_ctrl.Float to equal the ID consumer domain (input id_float, 1 bit, added to the port list).
  - When ex_ctrl.DW = 1, the match covers both {ex_dest[4:1],0} and {ex_dest[4:1],1}.
  - The register-0 exclusion applies to the integer domain only.
- Undefined:
  - Float and DW are forced to 0 in all stage registers.
  - The id_float port is absent.
  - Hazard compare is integer-only.

## Structure
- Package `ctrl_pkg` holds:
  - `ctrl_t` and the bit-index constants;
  - `CTRL_BUBBLE`;
  - WBSrc encodings: ALU = 0, MEM = 1, LUI = 2, PC4 = 3;
  - ExOp encodings: 000, 001, 010, 011, 100, 101, 111.
- One sub-module, `hazard_detect`: combinational generation of `lu`, including the FP/DW matching.

## Test plan
- Lw (RegWrite = 1, WBSrc = 1, dest 8), then add with rs = 8 → the next cycle shows `stall` = 1 and ex_ctrl = 0. The add reaches `ex_ctrl` 2 cycles after the lw was in EX.
- Lw to dest 0, then a consumer of r0 → `stall` never asserts.
- Mult with MULDIV_LAT = 4 → `stall` high for 3 cycles; `mem_ctrl` = 0 for 3 cycles; `ex_ctrl` stays at ExOp = 010.
- `ex_branch_taken` = 1 while `lu` = 1 → `flush_if` = 1, `stall` = 0, and ex_ctrl = 0 next cycle.
- Jump bundle (Jump = 1) in ID → `flush_if` = 1 that cycle, and ex_ctrl[13] = 1 next cycle.
- `rst` asserted with md_cnt = 2 → after the edge all outputs are 0 and `stall` = 0. With `CTRL_PIPE_FP_EN`: ldc1 (DW = 1, dest 4) followed by an FP reader of f5 → `stall` = 1.
